// File: rtl/trigger_arbiter_pkg.sv
// Shared definitions for the trigger arbiter: FSM encoding, default word width
// and the channel-id width helper.
package trigger_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 377;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int ch_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trigger_arbiter_rr_select.sv
// Rotating-priority search: first requesting channel from (ptr+1) mod N_CH upward.
module rr_select #(
  parameter int N_CH        = 4,
  parameter int CH_ID_WIDTH = 2
) (
  input  logic [N_CH-1:0]        req,
  input  logic [CH_ID_WIDTH-1:0] ptr,
  output logic [CH_ID_WIDTH-1:0] grant,
  output logic                   any
);

  logic [N_CH-1:0] rot_s;

  // Rotate so bit i holds channel (ptr+1+i) mod N_CH; ptr < N_CH keeps it within the doubled vector.
  assign rot_s = N_CH'({req, req} >> (int'(ptr) + 1));

  // Scan from the far end so the nearest requester after ptr is the last one written.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        any   = 1'b1;
        grant = CH_ID_WIDTH'((int'(ptr) + 1 + i) % N_CH);
      end else begin
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/trigger_arbiter.sv
// Frame-locked round-robin merge of N_CH trigger streams into one registered output.
// Optional stall abort is enabled by defining TRIGGER_ARBITER_TIMEOUT_EN.
module trigger_arbiter
  import trigger_arbiter_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_ID_WIDTH   = ch_id_width(N_CH)
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [N_CH*DATA_WIDTH-1:0] CH_DATA,
  input  logic [N_CH-1:0]            CH_VALID,
  input  logic [N_CH-1:0]            CH_LAST,
  output logic [N_CH-1:0]            CH_READY,
  output logic [DATA_WIDTH-1:0]      DOUT,
  output logic                       oVALID,
  output logic                       oLAST,
  output logic [CH_ID_WIDTH-1:0]     oCH_ID,
  input  logic                       iREADY,
  output logic                       BUSY,
  output logic                       TIMEOUT_ERR
);

  if (N_CH < 2 || N_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("trigger_arbiter: unsupported N_CH or TIMEOUT_CYCLES");
  end

  arb_state_t             state_r, state_nxt;
  logic [CH_ID_WIDTH-1:0] ptr_r, ptr_nxt, grant_r, grant_nxt, sel_s;
  logic                   any_s, ready_en_s, xfer_s;
  logic [DATA_WIDTH-1:0]  sel_data_s, dout_r;
  logic                   ovalid_r, olast_r, timeout_nxt;
  logic [CH_ID_WIDTH-1:0] och_id_r;

  rr_select #(.N_CH(N_CH), .CH_ID_WIDTH(CH_ID_WIDTH)) u_rr_select (
    .req   (CH_VALID),
    .ptr   (ptr_r),
    .grant (sel_s),
    .any   (any_s)
  );

  assign ready_en_s = (state_r == ST_LOCKED) && (!ovalid_r || iREADY);
  assign CH_READY   = ready_en_s ? ({{(N_CH-1){1'b0}}, 1'b1} << grant_r) : '0;
  assign xfer_s     = ready_en_s && CH_VALID[grant_r];

  // Word mux for the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_r == CH_ID_WIDTH'(k)) begin
        sel_data_s = CH_DATA[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

`ifdef TRIGGER_ARBITER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_r, stall_nxt;
  logic               timeout_err_r;
`endif

  // Next-state: arbitrate in IDLE, release on the last word (or on a stall abort).
  always_comb begin
    state_nxt   = state_r;
    ptr_nxt     = ptr_r;
    grant_nxt   = grant_r;
    timeout_nxt = 1'b0;
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
    stall_nxt   = stall_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          grant_nxt = sel_s;
          state_nxt = ST_LOCKED;
        end else begin
          state_nxt = ST_IDLE;
        end
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
        stall_nxt = '0;
`endif
      end
      ST_LOCKED: begin
        if (xfer_s && CH_LAST[grant_r]) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = grant_r;
        end else begin
          state_nxt = ST_LOCKED;
        end
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
        // A valid-but-backpressured cycle is not a stall by the source.
        if (xfer_s || CH_VALID[grant_r]) begin
          stall_nxt = '0;
        end else if (stall_r == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          stall_nxt   = '0;
          state_nxt   = ST_IDLE;
          ptr_nxt     = grant_r;
          timeout_nxt = 1'b1;
        end else begin
          stall_nxt = stall_r + STALL_W'(1);
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= ST_IDLE;
      ptr_r   <= CH_ID_WIDTH'(N_CH - 1);
      grant_r <= '0;
    end else begin
      state_r <= state_nxt;
      ptr_r   <= ptr_nxt;
      grant_r <= grant_nxt;
    end
  end

  // Output register: load on transfer, hold under backpressure, drop valid once accepted.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dout_r   <= '0;
      ovalid_r <= 1'b0;
      olast_r  <= 1'b0;
      och_id_r <= '0;
    end else if (xfer_s) begin
      dout_r   <= sel_data_s;
      ovalid_r <= 1'b1;
      olast_r  <= CH_LAST[grant_r];
      och_id_r <= grant_r;
    end else if (iREADY) begin
      ovalid_r <= 1'b0;
    end
  end

`ifdef TRIGGER_ARBITER_TIMEOUT_EN
  // Stall counter and one-cycle abort pulse.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      stall_r       <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      stall_r       <= stall_nxt;
      timeout_err_r <= timeout_nxt;
    end
  end
  assign TIMEOUT_ERR = timeout_err_r;
`else
  assign TIMEOUT_ERR = timeout_nxt & 1'b0;
`endif

  assign DOUT   = dout_r;
  assign oVALID = ovalid_r;
  assign oLAST  = olast_r;
  assign oCH_ID = och_id_r;
  assign BUSY   = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_trigger_arbiter.sv
// Self-checking bench for trigger_arbiter: random frames against a cycle-level
// behavioural model of the arbitration rules, plus directed scenarios.
module tb_trigger_arbiter;
  localparam int N   = 4;
  localparam int DW  = 377;
  localparam int TO  = 64;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_valid, ch_last, ch_ready;
  logic [DW-1:0]   dout;
  logic            ovalid, olast, iready, busy, timeout_err;
  logic [CHW-1:0]  och_id;

  always #5 clk = ~clk;

  trigger_arbiter #(.N_CH(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESETN(rst_n), .CH_DATA(ch_data), .CH_VALID(ch_valid),
    .CH_LAST(ch_last), .CH_READY(ch_ready), .DOUT(dout), .oVALID(ovalid),
    .oLAST(olast), .oCH_ID(och_id), .iREADY(iready), .BUSY(busy),
    .TIMEOUT_ERR(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_data [N][$];
  bit            src_last [N][$];
  bit            en [N];
  bit            rdy_in;

  // behavioural model state
  bit            m_idle, m_ovalid, m_olast, m_to;
  int            m_last, m_grant, m_stall, m_id;
  logic [DW-1:0] m_dout;
  bit            out_in_frame;
  int            out_frames[$], out_first_cyc[$];
  int            words_out, words_in, cyc, last_xfer_cyc, to_seen_cyc;
  logic [N-1:0]  samp_ready;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < DW; b += 32) w = (w << 32) | DW'($urandom);
    return w;
  endfunction

  // First requester strictly after 'last', wrapping around.
  function automatic int rr_pick(logic [N-1:0] req, int last);
    int c;
    c = last;
    repeat (N) begin
      c = (c + 1) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit pending();
    bit p;
    p = !m_idle || m_ovalid;
    for (int c = 0; c < N; c++) if (src_data[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push_frame(int ch, int len);
    for (int i = 0; i < len; i++) begin
      src_data[ch].push_back(rand_word());
      src_last[ch].push_back(i == len - 1);
      words_in++;
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_ovalid = 1'b0; m_olast = 1'b0; m_to = 1'b0;
    m_last = N - 1; m_grant = 0; m_stall = 0; m_id = 0; m_dout = '0;
    out_in_frame = 1'b0;
    out_frames.delete(); out_first_cyc.delete();
    words_out = 0; words_in = 0;
    for (int c = 0; c < N; c++) begin
      src_data[c].delete(); src_last[c].delete(); en[c] = 1'b1;
    end
    rdy_in = 1'b1;
    ch_valid = '0; ch_last = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive sources, compare DUT with the model mid-cycle, advance the model.
  task automatic step();
    logic [N-1:0] req, exp_ready;
    bit xfer, arb, to_now, acc;
    int sel;
    req = '0;
    for (int c = 0; c < N; c++) begin
      if (src_data[c].size() > 0 && en[c]) begin
        ch_valid[c] = 1'b1;
        ch_data[c*DW +: DW] = src_data[c][0];
        ch_last[c] = src_last[c][0];
        req[c] = 1'b1;
      end else begin
        ch_valid[c] = 1'b0;
        ch_last[c] = 1'b0;
      end
    end
    iready = rdy_in;
    #4;
    xfer   = !m_idle && req[m_grant] && (!m_ovalid || rdy_in);
    arb    = m_idle && (req != '0);
    sel    = arb ? rr_pick(req, m_last) : -1;
    to_now = 1'b0;
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
    if (!m_idle && !req[m_grant]) to_now = (m_stall + 1 >= TO);
`endif
    exp_ready = '0;
    if (!m_idle && (!m_ovalid || rdy_in)) exp_ready[m_grant] = 1'b1;

    checks++;
    if (busy !== !m_idle) begin
      errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, !m_idle);
    end
    checks++;
    if (ch_ready !== exp_ready) begin
      errors++; $display("FAIL ch_ready cyc=%0d: got %b expected %b", cyc, ch_ready, exp_ready);
    end
    checks++;
    if (ovalid !== m_ovalid) begin
      errors++; $display("FAIL ovalid cyc=%0d: got %b expected %b", cyc, ovalid, m_ovalid);
    end
    checks++;
    if (timeout_err !== m_to) begin
      errors++; $display("FAIL timeout_err cyc=%0d: got %b expected %b", cyc, timeout_err, m_to);
    end
    if (m_ovalid) begin
      checks++;
      if (dout !== m_dout) begin
        errors++; $display("FAIL dout cyc=%0d: got %h expected %h", cyc, dout, m_dout);
      end
      checks++;
      if (och_id !== CHW'(m_id) || olast !== m_olast) begin
        errors++; $display("FAIL och_id/olast cyc=%0d: got %0d/%b expected %0d/%b",
                           cyc, och_id, olast, m_id, m_olast);
      end
    end
    samp_ready = ch_ready;
    if (timeout_err === 1'b1) to_seen_cyc = cyc;
    if (xfer) last_xfer_cyc = cyc;
    acc = m_ovalid && rdy_in;
    if (acc) begin
      words_out++;
      if (!out_in_frame) begin
        out_frames.push_back(m_id);
        out_first_cyc.push_back(cyc);
      end
      out_in_frame = !m_olast;
    end

    @(posedge clk);
    #1;
    cyc++;
    m_to = to_now;
    if (xfer) begin
      m_dout = src_data[m_grant].pop_front();
      m_olast = src_last[m_grant].pop_front();
      m_id = m_grant; m_ovalid = 1'b1; m_stall = 0;
      if (m_olast) begin m_idle = 1'b1; m_last = m_grant; end
    end else begin
      if (acc) m_ovalid = 1'b0;
      if (!m_idle) begin
        if (req[m_grant]) m_stall = 0; else m_stall++;
      end
      if (to_now) begin
        m_idle = 1'b1; m_last = m_grant; m_stall = 0; out_in_frame = 1'b0;
      end
    end
    if (arb) begin m_idle = 1'b0; m_grant = sel; m_stall = 0; end
  endtask

  task automatic run_drain(int budget);
    int n;
    n = 0;
    for (int c = 0; c < N; c++) en[c] = 1'b1;
    rdy_in = 1'b1;
    while (pending() && n < budget) begin step(); n++; end
    checks++;
    if (pending()) begin
      errors++; $display("FAIL drain: still pending after %0d cycles, required idle", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    ch_valid = '1; ch_last = '1; ch_data = '1; iready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ovalid, olast, busy, timeout_err} !== 4'b0000 || dout !== '0 || och_id !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b l=%b b=%b t=%b id=%0d expected all zero",
                         ovalid, olast, busy, timeout_err, och_id);
    end
    checks++;
    if (ch_ready !== '0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", ch_ready);
    end
    ch_valid = '0; ch_last = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    push_frame(0, 3); push_frame(1, 3); push_frame(2, 3); push_frame(3, 3); push_frame(0, 3);
    run_drain(200);
    checks++;
    if (out_frames.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d frames expected 5", out_frames.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (out_frames[i] != exp_order[i]) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, out_frames[i], exp_order[i]);
        end
        if (i > 0) begin
          checks++;
          if (out_first_cyc[i] - out_first_cyc[i-1] != 4) begin
            errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", i,
                               out_first_cyc[i] - out_first_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    int n;
    apply_reset();
    push_frame(1, 4);
    n = 0;
    while (src_data[1].size() > 2 && n < 20) begin step(); n++; end
    push_frame(2, 1);
    run_drain(100);
    checks++;
    if (out_frames.size() != 2 || out_frames[0] != 1 || out_frames[$] != 2) begin
      errors++; $display("FAIL interleave_order: got %0d frames first=%0d expected 2 frames 1 then 2",
                         out_frames.size(), (out_frames.size() > 0) ? out_frames[0] : -1);
    end
  endtask

  task automatic test_back_pressure();
    int n;
    apply_reset();
    push_frame(0, 6);
    n = 0;
    while (src_data[0].size() > 3 && n < 20) begin step(); n++; end
    rdy_in = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (samp_ready !== '0) begin
        errors++; $display("FAIL stall_ready: got %b expected 0", samp_ready);
      end
    end
    run_drain(100);
    checks++;
    if (words_out != 6) begin
      errors++; $display("FAIL stall_words: got %0d expected 6", words_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    apply_reset();
    push_frame(3, 4);
    n = 0;
    while (src_data[3].size() > 3 && n < 20) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovalid !== 1'b0 || ch_ready !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset: got v=%b r=%b b=%b expected 0", ovalid, ch_ready, busy);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(3, 2); push_frame(0, 2);
    run_drain(100);
    checks++;
    if (out_frames.size() != 2 || out_frames[0] != 0 || out_frames[$] != 3) begin
      errors++; $display("FAIL midreset_order: got %0d frames first=%0d expected 0 then 3",
                         out_frames.size(), (out_frames.size() > 0) ? out_frames[0] : -1);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    for (int c = 0; c < N; c++) en[c] = (c == 1);
    push_frame(1, 4); push_frame(2, 1);
    n = 0;
    while (src_data[1].size() > 2 && n < 20) begin step(); n++; end
    en[1] = 1'b0; en[2] = 1'b1;
`ifdef TRIGGER_ARBITER_TIMEOUT_EN
    to_seen_cyc = -1;
    n = 0;
    while (to_seen_cyc < 0 && n < 150) begin step(); n++; end
    // Pulse is raised at the TO-th edge after the transfer edge, so it is sampled TO+1 cycles later.
    checks++;
    if (to_seen_cyc - last_xfer_cyc != TO + 1) begin
      errors++; $display("FAIL timeout_delay: got %0d expected %0d", to_seen_cyc - last_xfer_cyc, TO + 1);
    end
    src_data[1].delete(); src_last[1].delete();
    run_drain(100);
    checks++;
    if (out_frames.size() != 2 || out_frames[$] != 2) begin
      errors++; $display("FAIL timeout_next_grant: got %0d frames last=%0d expected 2",
                         out_frames.size(), (out_frames.size() > 0) ? out_frames[$] : -1);
    end
`else
    repeat (TO + 16) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL hold_locked: got busy=%b expected 1", busy);
    end
`endif
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    for (int f = 0; f < 40; f++) push_frame($urandom_range(0, N - 1), $urandom_range(1, 5));
    n = 0;
    while (pending() && n < 3000) begin
      for (int c = 0; c < N; c++) en[c] = ($urandom_range(0, 3) != 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    run_drain(500);
    checks++;
    if (words_out != words_in) begin
      errors++; $display("FAIL random_words: got %0d expected %0d", words_out, words_in);
    end
  endtask

  initial begin
    cyc = 0; last_xfer_cyc = 0; to_seen_cyc = -1;
    ch_data = '0; ch_valid = '0; ch_last = '0; iready = 1'b1; rst_n = 1'b1;
    test_reset();
    test_round_robin();
    test_no_interleave();
    test_back_pressure();
    test_reset_mid_frame();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_arbiter.md
TRIGGER_ARBITER -- requirements
Module: trigger_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of trigger channels merged; legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 377: per-channel trigger word width (256 data + 2x48 timestamps + 2x12 + 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64: stall limit, used only when TRIGGER_ARBITER_TIMEOUT_EN is defined.
REQ-004 SHALL derive localparam CH_ID_WIDTH = max(1, clog2(N_CH)).
REQ-005 SHALL have ports, clock and reset first:
- CLK  in  1  single block clock.
- RESETN  in  1  asynchronous, active-low reset.
- CH_DATA  in  N_CH*DATA_WIDTH  channel words; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- CH_VALID  in  N_CH  per-channel word valid.
- CH_LAST  in  N_CH  per-channel last word of a trigger frame.
- CH_READY  out  N_CH  per-channel accept.
- DOUT  out  DATA_WIDTH  merged word.
- oVALID  out  1  DOUT valid.
- oLAST  out  1  DOUT is the last word of its frame.
- oCH_ID  out  CH_ID_WIDTH  source channel of DOUT.
- iREADY  in  1  downstream accept.
- BUSY  out  1  a frame is locked.
- TIMEOUT_ERR  out  1  one-cycle stall-abort pulse.

Function
REQ-006 SHALL implement a state machine with states IDLE and LOCKED.
REQ-007 In IDLE, if any CH_VALID is set, SHALL grant the first requesting channel searching from (ptr+1) mod N_CH upward with wrap-around, register the grant, and move to LOCKED; it SHALL NOT accept data in IDLE.
REQ-008 SHALL drive CH_READY[g] = LOCKED && g==grant && (!oVALID || iREADY), and all other CH_READY bits to 0.
REQ-009 On a transfer (CH_VALID[g] && CH_READY[g]), SHALL register DOUT, oLAST = CH_LAST[g], oCH_ID = g, and oVALID = 1 on the next edge (1-cycle latency).
REQ-010 SHALL keep DOUT, oLAST, and oCH_ID stable while oVALID && !iREADY; oVALID SHALL clear after an accepted word when no new transfer occurs in that cycle.
REQ-011 SHALL allow back-to-back transfers within a frame at one word per cycle when iREADY stays high.
REQ-012 On a transfer with CH_LAST[g] = 1, SHALL set ptr = g and return to IDLE; a single-word frame (VALID and LAST together) SHALL be legal.
REQ-013 SHALL never interleave words from different channels within a frame.
REQ-014 Between frames, SHALL insert exactly one idle arbitration cycle, including when the same channel is re-granted.
REQ-015 SHALL drive BUSY = (state == LOCKED).

Reset
REQ-016 On RESETN low, SHALL asynchronously set state = IDLE, ptr = N_CH-1 (channel 0 wins first), grant = 0, oVALID = 0, oLAST = 0, DOUT = 0, oCH_ID = 0, TIMEOUT_ERR = 0, and the stall counter to 0.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame; after release, arbitration SHALL restart from channel 0.
REQ-018 All CH_READY bits SHALL be 0 during reset and in IDLE.

Configuration
REQ-019 With TRIGGER_ARBITER_TIMEOUT_EN defined, in LOCKED the block SHALL count consecutive cycles with CH_VALID[grant] = 0, clear the count on every transfer, and, when the count reaches TIMEOUT_CYCLES, SHALL return to IDLE, set ptr = grant, and pulse TIMEOUT_ERR high for one cycle; no oLAST word SHALL be fabricated.
REQ-020 Without TRIGGER_ARBITER_TIMEOUT_EN, SHALL have no stall counter, tie TIMEOUT_ERR to 0, and hold LOCKED indefinitely.

Structure
REQ-021 SHALL take the state encoding (IDLE/LOCKED) and the default DATA_WIDTH constant from the shared package trigger_arbiter_pkg.
REQ-022 SHALL place the rotating-priority search in sub-module rr_select (inputs: request vector and ptr; outputs: grant index and any-request flag).

Verification
REQ-023 After reset, CH_VALID = 4'b1111, all frames 3 words long, iREADY = 1 -> frames output from channels 0, 1, 2, 3, 0 in that order; oCH_ID matches the source; 3 words per frame plus 1 idle cycle.
REQ-024 Channel 2 sends a 1-word frame while channel 1 is mid-frame -> channel 2's word appears only after channel 1's oLAST; no interleaving.
REQ-025 iREADY low for 5 cycles mid-frame -> DOUT/oCH_ID held constant, CH_READY[g] = 0, no word lost or duplicated.
REQ-026 RESETN pulsed low on word 2 of a 4-word channel-3 frame -> oVALID = 0 immediately; the next grant is channel 0 if it is requesting.
REQ-027 With TRIGGER_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 64, channel 1 drops CH_VALID mid-frame -> TIMEOUT_ERR pulses exactly 64 cycles after the last transfer; the next grant goes to channel 2; without the macro, BUSY stays 1.
